acc_feeder: RTL and testbench

//  Upstream sequencer for the CORDIC term/fp-accumulator Avalon slave. The CPU pushes fp32 samples

---
 rtl/acc_feeder_if.sv | 13 +
 rtl/acc_feeder.sv | 201 ++++++++++++++++++++
 tb/tb_acc_feeder.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_feeder_if.sv
// Avalon-style bus bundle used for both the CSR slave port and the accumulator master port.
interface acc_feeder_if #(
  parameter int AW = 1
);
  logic [AW-1:0] address;
  logic          write;
  logic          read;
  logic [31:0]   writedata;
  logic [31:0]   readdata;

  modport master (output address, output write, output read, output writedata, input readdata);
  modport slave  (input address, input write, input read, input writedata, output readdata);
endinterface

// File: rtl/acc_feeder.sv
// Sample FIFO + sequencer feeding the fp accumulator: clear, paced sample writes, drain, read-back.
// Optional feature macro: ACC_FEEDER_IRQ_EN (CTRL bit3 irq enable, irq = done & irq_en).
module acc_feeder #(
  parameter int FIFO_DEPTH = 16,
  parameter int GAP        = 12,
  parameter int DRAIN      = 12,
  parameter int READ_LAT   = 11
) (
  input  logic         clk,
  input  logic         reset_n,
  acc_feeder_if.slave  csr,
  acc_feeder_if.master acc,
  output logic         irq
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int MAXC = (GAP > DRAIN) ? ((GAP > READ_LAT) ? GAP : READ_LAT)
                                      : ((DRAIN > READ_LAT) ? DRAIN : READ_LAT);
  localparam int CW   = $clog2(MAXC) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_GAPW  = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_READ  = 3'd5;
  localparam logic [2:0] S_WAITR = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic          done_q, done_d, ovf_q, ovf_d, irq_q, irq_d;
  logic [31:0]   result_q, result_d, rdata_q, rdata_d, m_wdata_q, m_wdata_d;
  logic          m_write_q, m_write_d, m_read_q, m_read_d, m_addr_q, m_addr_d;
`ifdef ACC_FEEDER_IRQ_EN
  logic          irq_en_q, irq_en_d;
`endif

  logic [AW:0]   fifo_count;
  logic          fifo_full, fifo_empty, sample_wr, ctrl_wr, push, pop, start, capture, busy;
  logic [31:0]   status;

  // Next-state logic: FIFO pointers, sequencer FSM, CSR flags and registered bus outputs.
  always_comb begin
    fifo_count = wr_ptr_q - rd_ptr_q;
    fifo_full  = (fifo_count == (AW+1)'(FIFO_DEPTH));
    fifo_empty = (fifo_count == {(AW+1){1'b0}});
    sample_wr  = csr.write & (csr.address == 2'd0);
    ctrl_wr    = csr.write & (csr.address == 2'd1);
    push       = sample_wr & ~fifo_full;
    busy       = (state_q != S_IDLE);
    start      = ctrl_wr & csr.writedata[0] & ~busy;
    status     = {16'h0000, 8'(fifo_count), 3'b000, fifo_empty, fifo_full, ovf_q, busy, done_q};

    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    capture = 1'b0;
    // GAPW runs GAP-1 cycles so consecutive m_write pulses land exactly GAP apart
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
        else       state_d = S_IDLE;
      end
      S_CLEAR: begin
        state_d = S_GAPW;
        cnt_d   = CW'(GAP - 2);
      end
      S_GAPW: begin
        if (cnt_q == {CW{1'b0}}) begin
          if (!fifo_empty) begin
            state_d = S_SEND;
            pop     = 1'b1;
          end else begin
            state_d = S_DRAIN;
            cnt_d   = CW'(DRAIN - 1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_SEND: begin
        state_d = S_GAPW;
        cnt_d   = CW'(GAP - 2);
      end
      S_DRAIN: begin
        if (cnt_q == {CW{1'b0}}) state_d = S_READ;
        else                     cnt_d   = cnt_q - CW'(1);
      end
      S_READ: begin
        state_d = S_WAITR;
        cnt_d   = CW'(READ_LAT - 1);
      end
      S_WAITR: begin
        if (cnt_q == {CW{1'b0}}) begin
          state_d = S_IDLE;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase

    if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    else      wr_ptr_d = wr_ptr_q;

    if (ctrl_wr && csr.writedata[2] && !busy) rd_ptr_d = wr_ptr_q;
    else if (pop)                             rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    else                                      rd_ptr_d = rd_ptr_q;

    if (capture)                                  done_d = 1'b1;
    else if ((ctrl_wr && csr.writedata[1]) || start) done_d = 1'b0;
    else                                          done_d = done_q;

    if (sample_wr && fifo_full)          ovf_d = 1'b1;
    else if (ctrl_wr && csr.writedata[1]) ovf_d = 1'b0;
    else                                  ovf_d = ovf_q;

    if (capture) result_d = acc.readdata;
    else         result_d = result_q;

`ifdef ACC_FEEDER_IRQ_EN
    if (ctrl_wr) irq_en_d = csr.writedata[3];
    else         irq_en_d = irq_en_q;
    irq_d = done_d & irq_en_d;
`else
    irq_d = 1'b0;
`endif

    if (csr.read) begin
      case (csr.address)
        2'd2:    rdata_d = status;
        2'd3:    rdata_d = result_q;
        default: rdata_d = 32'h0000_0000;
      endcase
    end else begin
      rdata_d = 32'h0000_0000;
    end

    m_write_d = (state_d == S_CLEAR) | (state_d == S_SEND);
    m_read_d  = (state_d == S_READ);
    m_addr_d  = (state_d == S_CLEAR) | (state_d == S_READ);
    if (state_d == S_SEND) m_wdata_d = mem_q[rd_ptr_q[AW-1:0]];
    else                   m_wdata_d = 32'h0000_0000;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CW{1'b0}};
      wr_ptr_q  <= {(AW+1){1'b0}};
      rd_ptr_q  <= {(AW+1){1'b0}};
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      irq_q     <= 1'b0;
      result_q  <= 32'h0000_0000;
      rdata_q   <= 32'h0000_0000;
      m_wdata_q <= 32'h0000_0000;
      m_write_q <= 1'b0;
      m_read_q  <= 1'b0;
      m_addr_q  <= 1'b0;
`ifdef ACC_FEEDER_IRQ_EN
      irq_en_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      irq_q     <= irq_d;
      result_q  <= result_d;
      rdata_q   <= rdata_d;
      m_wdata_q <= m_wdata_d;
      m_write_q <= m_write_d;
      m_read_q  <= m_read_d;
      m_addr_q  <= m_addr_d;
`ifdef ACC_FEEDER_IRQ_EN
      irq_en_q  <= irq_en_d;
`endif
    end
  end

  // Sample storage; contents need no reset because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= csr.writedata;
  end

  assign acc.address   = m_addr_q;
  assign acc.write     = m_write_q;
  assign acc.read      = m_read_q;
  assign acc.writedata = m_wdata_q;
  assign csr.readdata  = rdata_q;
  assign irq           = irq_q;
endmodule

// File: tb/tb_acc_feeder.sv
// Directed self-checking bench for acc_feeder with a behavioural fp accumulator model.
module tb_acc_feeder;
  localparam int DEPTH = 16, GAP = 12, DRAIN = 12, READ_LAT = 11;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic irq;
  int   pass_cnt = 0, total_cnt = 0;

  acc_feeder_if #(.AW(2)) csr ();
  acc_feeder_if #(.AW(1)) acc ();

  acc_feeder #(.FIFO_DEPTH(DEPTH), .GAP(GAP), .DRAIN(DRAIN), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .csr(csr), .acc(acc), .irq(irq));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic real fp32_to_real(input logic [31:0] b);
    real r;
    int  e;
    if (b[30:0] == 31'h0) return 0.0;
    e = int'(b[30:23]) - 127;
    r = 1.0 + real'(b[22:0]) / 8388608.0;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return b[31] ? -r : r;
  endfunction

  function automatic logic [31:0] real_to_fp32(input real r);
    real a;
    int  e;
    logic s;
    logic [22:0] m;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m = 23'($rtoi((a - 1.0) * 8388608.0));
    return {s, 8'(e), m};
  endfunction

  // Downstream accumulator model and bus monitor
  int          wr_cyc[$];
  logic        wr_addr[$];
  logic [31:0] wr_data[$];
  int          rd_cyc[$];
  int          viol = 0;
  int          rd_at = -1;
  logic        prev_act = 1'b0;
  real         model_sum = 0.0;
  logic [31:0] rd_val = 32'h0;

  always @(negedge clk) begin
    acc.readdata = (cyc == rd_at) ? rd_val : 32'h0;
    if (acc.write) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(acc.address);
      wr_data.push_back(acc.writedata);
      if (acc.address) model_sum = 0.0;
      else             model_sum = model_sum + fp32_to_real(acc.writedata);
    end
    if (acc.read) begin
      rd_cyc.push_back(cyc);
      rd_at  = cyc + READ_LAT;
      rd_val = real_to_fp32(model_sum);
    end
    if ((acc.write && acc.read) || ((acc.write || acc.read) && prev_act)) viol++;
    prev_act = acc.write || acc.read;
  end

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    csr.address = a; csr.writedata = d; csr.write = 1'b1;
    @(negedge clk);
    csr.write = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    csr.address = a; csr.read = 1'b1;
    @(negedge clk);
    csr.read = 1'b0;
    d = csr.readdata;
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] s;
    int k;
    s = 32'h2; k = 0;
    while (s[1] && k < 400) begin csr_rd(2'd2, s); k++; end
    if (s[1]) begin
      total_cnt++;
      $display("FAIL %s_idle_timeout: busy=%0b expected 0", name, s[1]);
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    csr_rd(2'd2, v);
    total_cnt++; if (v !== 32'h0000_0010) $display("FAIL reset_status: got %h expected %h", v, 32'h10); else pass_cnt++;
    csr_rd(2'd3, v);
    total_cnt++; if (v !== 32'h0) $display("FAIL reset_result: got %h expected 0", v); else pass_cnt++;
    total_cnt++; if (wr_cyc.size() + rd_cyc.size() !== 0) $display("FAIL reset_bus_quiet: got %0d events expected 0", wr_cyc.size() + rd_cyc.size()); else pass_cnt++;
    total_cnt++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq); else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [31:0] v;
    logic [31:0] smp [3];
    int wb, rb;
    smp[0] = 32'h3F80_0000; smp[1] = 32'h4000_0000; smp[2] = 32'h4040_0000;
    wb = wr_cyc.size(); rb = rd_cyc.size();
    for (int i = 0; i < 3; i++) csr_wr(2'd0, smp[i]);
    csr_wr(2'd1, 32'h1);
    wait_idle("basic");
    total_cnt++; if (wr_cyc.size() - wb !== 4) $display("FAIL basic_wr_count: got %0d expected 4", wr_cyc.size() - wb); else pass_cnt++;
    total_cnt++; if (wr_addr[wb] !== 1'b1 || wr_data[wb] !== 32'h0) $display("FAIL basic_clear: got addr %b data %h expected 1/0", wr_addr[wb], wr_data[wb]); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (wr_addr[wb+1+i] !== 1'b0 || wr_data[wb+1+i] !== smp[i]) $display("FAIL basic_sample%0d: got %b/%h expected 0/%h", i, wr_addr[wb+1+i], wr_data[wb+1+i], smp[i]); else pass_cnt++;
      total_cnt++;
      if (wr_cyc[wb+1+i] - wr_cyc[wb+i] !== GAP) $display("FAIL basic_gap%0d: got %0d expected %0d", i, wr_cyc[wb+1+i] - wr_cyc[wb+i], GAP); else pass_cnt++;
    end
    total_cnt++; if (rd_cyc.size() - rb !== 1) $display("FAIL basic_rd_count: got %0d expected 1", rd_cyc.size() - rb); else pass_cnt++;
    total_cnt++; if (rd_cyc[rb] - wr_cyc[wb+3] !== GAP + DRAIN) $display("FAIL basic_drain: got %0d expected %0d", rd_cyc[rb] - wr_cyc[wb+3], GAP + DRAIN); else pass_cnt++;
    csr_rd(2'd3, v);
    total_cnt++; if (v !== 32'h40C0_0000) $display("FAIL basic_result: got %h expected 40c00000", v); else pass_cnt++;
    csr_rd(2'd2, v);
    total_cnt++; if (v !== 32'h0000_0011) $display("FAIL basic_status: got %h expected 00000011", v); else pass_cnt++;
`ifndef ACC_FEEDER_IRQ_EN
    total_cnt++; if (irq !== 1'b0) $display("FAIL basic_irq_tied: got %b expected 0", irq); else pass_cnt++;
`endif
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    int wb;
    wb = wr_cyc.size();
    for (int i = 0; i < DEPTH + 2; i++) csr_wr(2'd0, real_to_fp32(real'(i + 1)));
    csr_rd(2'd2, v);
    total_cnt++; if (v !== 32'h0000_100D) $display("FAIL ovf_status: got %h expected 0000100d", v); else pass_cnt++;
    csr_wr(2'd1, 32'h2);
    csr_rd(2'd2, v);
    total_cnt++; if (v !== 32'h0000_1008) $display("FAIL ovf_cleared: got %h expected 00001008", v); else pass_cnt++;
    csr_wr(2'd1, 32'h1);
    wait_idle("ovf");
    total_cnt++; if (wr_cyc.size() - wb !== DEPTH + 1) $display("FAIL ovf_wr_count: got %0d expected %0d", wr_cyc.size() - wb, DEPTH + 1); else pass_cnt++;
    for (int i = 0; i < DEPTH; i++) begin
      total_cnt++;
      if (wr_data[wb+1+i] !== real_to_fp32(real'(i + 1))) $display("FAIL ovf_kept%0d: got %h expected %h", i, wr_data[wb+1+i], real_to_fp32(real'(i + 1))); else pass_cnt++;
    end
    csr_rd(2'd3, v);
    total_cnt++; if (v !== 32'h4308_0000) $display("FAIL ovf_result: got %h expected 43080000", v); else pass_cnt++;
  endtask

  task automatic test_empty();
    logic [31:0] v;
    int wb, rb;
    wb = wr_cyc.size(); rb = rd_cyc.size();
    csr_wr(2'd1, 32'h1);
    wait_idle("empty");
    total_cnt++; if (wr_cyc.size() - wb !== 1) $display("FAIL empty_wr_count: got %0d expected 1", wr_cyc.size() - wb); else pass_cnt++;
    total_cnt++; if (rd_cyc.size() - rb !== 1) $display("FAIL empty_rd_count: got %0d expected 1", rd_cyc.size() - rb); else pass_cnt++;
    total_cnt++; if (rd_cyc[rb] - wr_cyc[wb] !== GAP + DRAIN) $display("FAIL empty_read_delay: got %0d expected %0d", rd_cyc[rb] - wr_cyc[wb], GAP + DRAIN); else pass_cnt++;
    csr_rd(2'd3, v);
    total_cnt++; if (v !== 32'h0) $display("FAIL empty_result: got %h expected 0", v); else pass_cnt++;
    csr_rd(2'd2, v);
    total_cnt++; if (v !== 32'h0000_0011) $display("FAIL empty_status: got %h expected 00000011", v); else pass_cnt++;
  endtask

  task automatic test_ctrl();
    logic [31:0] v;
    int wb;
    csr_wr(2'd0, 32'h4080_0000);
    csr_wr(2'd0, 32'h4080_0000);
    csr_rd(2'd2, v);
    total_cnt++; if (v !== 32'h0000_0201) $display("FAIL ctrl_two_pushed: got %h expected 00000201", v); else pass_cnt++;
    csr_wr(2'd1, 32'h4);
    csr_rd(2'd2, v);
    total_cnt++; if (v !== 32'h0000_0011) $display("FAIL ctrl_flush: got %h expected 00000011", v); else pass_cnt++;
    wb = wr_cyc.size();
    csr_wr(2'd0, 32'h40A0_0000);
    csr_wr(2'd1, 32'h3);
    csr_rd(2'd2, v);
    total_cnt++; if (v !== 32'h0000_0102) $display("FAIL ctrl_start_clear: got %h expected 00000102", v); else pass_cnt++;
    wait_idle("ctrl");
    total_cnt++; if (wr_cyc.size() - wb !== 2 || wr_data[wb+1] !== 32'h40A0_0000) $display("FAIL ctrl_sent: got %0d writes expected 2 with 40a00000", wr_cyc.size() - wb); else pass_cnt++;
    csr_rd(2'd3, v);
    total_cnt++; if (v !== 32'h40A0_0000) $display("FAIL ctrl_result: got %h expected 40a00000", v); else pass_cnt++;
  endtask

  task automatic test_midrun();
    logic [31:0] v;
    int wb, rb;
    wb = wr_cyc.size(); rb = rd_cyc.size();
    csr_wr(2'd0, 32'h4080_0000);
    csr_wr(2'd0, 32'h40A0_0000);
    csr_wr(2'd1, 32'h1);
    repeat (2) @(negedge clk);
    csr_wr(2'd0, 32'h40C0_0000);
    csr_wr(2'd1, 32'h1);
    wait_idle("midrun");
    total_cnt++; if (wr_cyc.size() - wb !== 4) $display("FAIL midrun_wr_count: got %0d expected 4", wr_cyc.size() - wb); else pass_cnt++;
    total_cnt++; if (wr_data[wb+3] !== 32'h40C0_0000) $display("FAIL midrun_third: got %h expected 40c00000", wr_data[wb+3]); else pass_cnt++;
    total_cnt++; if (rd_cyc.size() - rb !== 1) $display("FAIL midrun_rd_count: got %0d expected 1", rd_cyc.size() - rb); else pass_cnt++;
    csr_rd(2'd3, v);
    total_cnt++; if (v !== 32'h4170_0000) $display("FAIL midrun_result: got %h expected 41700000", v); else pass_cnt++;
  endtask

  task automatic test_reset_midrun();
    logic [31:0] v;
    int rb, k, nw, nr;
    rb = rd_cyc.size();
    csr_wr(2'd0, 32'h40E0_0000);
    csr_wr(2'd1, 32'h1);
    k = 0;
    while (rd_cyc.size() == rb && k < 300) begin @(negedge clk); k++; end
    if (rd_cyc.size() == rb) begin
      total_cnt++;
      $display("FAIL rstmid_read_timeout: got 0 reads expected 1");
    end
    csr_wr(2'd0, 32'h4110_0000);
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    nw = wr_cyc.size(); nr = rd_cyc.size();
    csr_rd(2'd2, v);
    total_cnt++; if (v !== 32'h0000_0010) $display("FAIL rstmid_status: got %h expected 00000010", v); else pass_cnt++;
    csr_rd(2'd3, v);
    total_cnt++; if (v !== 32'h0) $display("FAIL rstmid_result: got %h expected 0", v); else pass_cnt++;
    repeat (READ_LAT + 4) @(negedge clk);
    csr_rd(2'd3, v);
    total_cnt++; if (v !== 32'h0) $display("FAIL rstmid_no_capture: got %h expected 0", v); else pass_cnt++;
    csr_rd(2'd2, v);
    total_cnt++; if (v !== 32'h0000_0010) $display("FAIL rstmid_status_late: got %h expected 00000010", v); else pass_cnt++;
    total_cnt++; if (wr_cyc.size() != nw || rd_cyc.size() != nr) $display("FAIL rstmid_bus_quiet: got %0d new events expected 0", wr_cyc.size() - nw + rd_cyc.size() - nr); else pass_cnt++;
    total_cnt++; if (irq !== 1'b0) $display("FAIL rstmid_irq: got %b expected 0", irq); else pass_cnt++;
  endtask

  task automatic test_irq();
    csr_wr(2'd0, 32'h3F80_0000);
    csr_wr(2'd1, 32'h9);
    wait_idle("irq");
`ifdef ACC_FEEDER_IRQ_EN
    total_cnt++; if (irq !== 1'b1) $display("FAIL irq_set: got %b expected 1", irq); else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++; if (irq !== 1'b1) $display("FAIL irq_held: got %b expected 1", irq); else pass_cnt++;
    csr_wr(2'd1, 32'hA);
    total_cnt++; if (irq !== 1'b0) $display("FAIL irq_cleared: got %b expected 0", irq); else pass_cnt++;
`else
    total_cnt++; if (irq !== 1'b0) $display("FAIL irq_disabled: got %b expected 0", irq); else pass_cnt++;
`endif
    total_cnt++; if (viol !== 0) $display("FAIL bus_spacing: got %0d violations expected 0", viol); else pass_cnt++;
  endtask

  initial begin
    csr.address = 2'd0; csr.writedata = 32'h0; csr.write = 1'b0; csr.read = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_empty();
    test_ctrl();
    test_midrun();
    test_reset_midrun();
    test_irq();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
